nrs_gen: RTL and testbench
==========================

# nrs_gen

NB-IoT narrowband reference signal (NRS) generator. It produces the pilot sign bits `nrs_r` and `nrs_i` that the channel-estimation complex multiplier uses to de-rotate received pilots, and it mirrors the transmit-side pilot mapping. For each OFDM symbol carrying NRS, it computes `c_init` from slot, symbol and cell ID. It then runs the 3GPP length-31 Gold sequence past the Nc and RB offset and streams NUM_PILOTS QPSK sign pairs over a valid/ready handshake.

## Interface
- SKIP, 1818, sequence bits discarded before the first pilot (Nc = 1600 plus 2·109 for m' = m + 109)
- NUM_PILOTS, 2, sign pairs emitted per start
- IDX_W, 1, width of `pilot_idx`; must satisfy 2^IDX_W ≥ NUM_PILOTS

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- ns  in  5  slot number, 0..19
- l  in  3  OFDM symbol index within the slot (5 or 6 for NRS)
- cell_id  in  9  N_ID^Ncell, 0..503
- busy  out  1  high in every state except IDLE
- c_init_o  out  31  registered c_init of the current request
- out_valid  out  1  a pilot sign pair is presented
- out_ready  in  1  consumer accepts the pair
- nrs_r  out  1  c(SKIP+2m); 1 = negative real part
- nrs_i  out  1  c(SKIP+2m+1); 1 = negative imaginary part
- pilot_idx  out  IDX_W  m of the presented pair
- done  out  1  one-cycle pulse after the last pair is accepted

## Operation
- `c_init` = 2^10·(7·(ns+1)+l+1)·(2·cell_id+1) + 2·cell_id + 1. Computed unsigned; the maximum is 151,582,703 and fits in 31 bits.
- LFSRs: `x1[30:0]`, `x2[30:0]`; bit 0 holds the current sample n.
  - One step shifts right.
  - `x1` new bit 30 = x1[0]^x1[3].
  - `x2` new bit 30 = x2[0]^x2[1]^x2[2]^x2[3].
  - Sequence bit c(n) = x1[0]^x2[0].
- FSM states: IDLE, INIT, SKIP, GEN_A, GEN_B, HOLD.
  - IDLE + start: latch ns/l/cell_id, go to INIT.
  - INIT: compute and register `c_init_o`; load x1 = 31'd1 and x2 = c_init; load skip counter = SKIP; go to SKIP, or to GEN_A if SKIP = 0.
  - SKIP: step both LFSRs once per cycle and decrement the counter; go to GEN_A when the counter reaches 0.
  - GEN_A: capture c into `nrs_r`, step, go to GEN_B.
  - GEN_B: capture c into `nrs_i`, step, set `out_valid`, go to HOLD.
  - HOLD with `out_valid && out_ready`:
    - If `pilot_idx` = NUM_PILOTS-1: clear valid, pulse `done`, go to IDLE.
    - Otherwise: clear valid, increment `pilot_idx`, go to GEN_A.
  - HOLD without ready: hold all outputs and LFSRs unchanged.
- LFSRs step only in SKIP, GEN_A and GEN_B.
- `start` is ignored while `busy`. Input changes after the start cycle are ignored.
- `nrs_r`, `nrs_i`, `pilot_idx` and `out_valid` are registered and stable while valid and not ready.

## Timing
- Reset (asynchronous, active-low): state IDLE; `busy`=0, `out_valid`=0, `done`=0, `nrs_r`=0, `nrs_i`=0, `pilot_idx`=0, `c_init_o`=0, `x1`=0, `x2`=0, skip counter=0.
  - Reset mid-operation aborts immediately. The next request restarts cleanly.
- Request sequence, counting the start-sampling edge as edge 0:
  - Edge 1: INIT; `c_init_o` valid.
  - Edges 2..SKIP+1: SKIP steps.
  - Edge SKIP+2: GEN_A.
  - Edge SKIP+3: GEN_B; first `out_valid` high, pilot 0.
  - Default latency: 1821 cycles.
- Per pair with ready tied high: `out_valid` is high for 1 cycle, then low for 2 cycles (GEN_A, GEN_B). Throughput is 1 pair per 3 cycles.
- `done` is high in the cycle after the final handshake edge. `busy` falls in the same cycle, and a new start is accepted in that cycle.
- `busy` rises in the cycle after the start edge.

## Test plan
- ns=0, l=5, cell_id=0 -> `c_init_o` = 13313 one cycle after the start edge.
- ns=19, l=6, cell_id=503 -> `c_init_o` = 151582703.
- SKIP=0, NUM_PILOTS=7, ns=0, l=5, cell_id=0 -> pairs m=0..4 are (0,0), m=5 is (1,0), m=6 is (1,1); `done` pulses once.
- Default parameters, random ns/l/cell_id, ready tied high -> first valid exactly 1821 cycles after the start edge. Sign pairs match a bit-accurate Gold-sequence model at c(1818..1821).
- Random out_ready backpressure -> pairs are held stable while stalled; no pair is lost or duplicated; the sequence is identical to the no-stall run.
- rst asserted during SKIP, plus start pulses while busy -> all outputs return to 0 immediately; a fresh start produces correct pilots; starts issued while busy have no effect.

Source files
------------

// File: rtl/nrs_gen.sv
// NB-IoT narrowband reference signal generator: derives c_init per NRS symbol and
// streams QPSK pilot sign pairs from the length-31 Gold sequence over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start; request fields latched on start
// INIT   | c_init registered, LFSRs and skip counter loaded
// SKIP   | discarding Nc + RB-offset sequence bits
// GEN_A  | capture real-part sign, step
// GEN_B  | capture imaginary-part sign, step, raise valid
// HOLD   | pair presented until accepted
module nrs_gen #(
  parameter int SKIP       = 1818,
  parameter int NUM_PILOTS = 2,
  parameter int IDX_W      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ns,
  input  logic [2:0]       l,
  input  logic [8:0]       cell_id,
  output logic             busy,
  output logic [30:0]      c_init_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             nrs_r,
  output logic             nrs_i,
  output logic [IDX_W-1:0] pilot_idx,
  output logic             done
);

  localparam int CNT_W = (SKIP < 2) ? 1 : $clog2(SKIP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SKIP,
    ST_GEN_A,
    ST_GEN_B,
    ST_HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       ns_q;
  logic [2:0]       l_q;
  logic [8:0]       cell_q;
  logic [30:0]      c_init_q;
  logic [30:0]      x1;
  logic [30:0]      x2;
  logic [CNT_W-1:0] skip_cnt;
  logic             nrs_r_q;
  logic             nrs_i_q;
  logic             valid_q;
  logic             done_q;
  logic [IDX_W-1:0] idx_q;

  logic             latch_req;
  logic             load_init;
  logic             step;
  logic             dec_skip;
  logic             cap_r;
  logic             cap_i;
  logic             accept;
  logic             last_pair;
  logic             c_bit;
  logic [30:0]      sym_fac;
  logic [30:0]      cell_fac;
  logic [30:0]      c_init_calc;

  // Product peaks at 18 bits before the 2^10 scale, so 31-bit arithmetic never wraps.
  assign sym_fac     = 31'(ns_q) * 31'd7 + 31'd7 + 31'(l_q) + 31'd1;
  assign cell_fac    = 31'({cell_q, 1'b1});
  assign c_init_calc = ((sym_fac * cell_fac) << 10) + cell_fac;

  assign c_bit     = x1[0] ^ x2[0];
  assign last_pair = (idx_q == IDX_W'(NUM_PILOTS - 1));
  assign accept    = valid_q && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    load_init = 1'b0;
    step      = 1'b0;
    dec_skip  = 1'b0;
    cap_r     = 1'b0;
    cap_i     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_req = 1'b1;
          state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        load_init = 1'b1;
        state_nxt = (SKIP == 0) ? ST_GEN_A : ST_SKIP;
      end
      ST_SKIP: begin
        step     = 1'b1;
        dec_skip = 1'b1;
        if (skip_cnt == CNT_W'(1)) state_nxt = ST_GEN_A;
      end
      ST_GEN_A: begin
        step      = 1'b1;
        cap_r     = 1'b1;
        state_nxt = ST_GEN_B;
      end
      ST_GEN_B: begin
        step      = 1'b1;
        cap_i     = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept) state_nxt = last_pair ? ST_IDLE : ST_GEN_A;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ns_q     <= '0;
      l_q      <= '0;
      cell_q   <= '0;
      c_init_q <= '0;
      x1       <= '0;
      x2       <= '0;
      skip_cnt <= '0;
      nrs_r_q  <= 1'b0;
      nrs_i_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (latch_req) begin
        ns_q   <= ns;
        l_q    <= l;
        cell_q <= cell_id;
      end
      if (load_init) begin
        c_init_q <= c_init_calc;
        x1       <= 31'd1;
        x2       <= c_init_calc;
        skip_cnt <= CNT_W'(SKIP);
        idx_q    <= '0;
      end else if (step) begin
        x1 <= {x1[0] ^ x1[3], x1[30:1]};
        x2 <= {x2[0] ^ x2[1] ^ x2[2] ^ x2[3], x2[30:1]};
      end
      if (dec_skip) skip_cnt <= skip_cnt - CNT_W'(1);
      if (cap_r) nrs_r_q <= c_bit;
      if (cap_i) begin
        nrs_i_q <= c_bit;
        valid_q <= 1'b1;
      end
      if (state == ST_HOLD && accept) begin
        valid_q <= 1'b0;
        if (last_pair) begin
          done_q <= 1'b1;
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign c_init_o  = c_init_q;
  assign out_valid = valid_q;
  assign nrs_r     = nrs_r_q;
  assign nrs_i     = nrs_i_q;
  assign pilot_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nrs_gen.sv
// Bench for nrs_gen: a Gold-sequence and handshake-timing model checks every cycle,
// with literal expectations pinning c_init and the first sequence bits.
module tb_nrs_gen;

  localparam int SKIP = 1818;
  localparam int NP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ns;
  logic [2:0]  l;
  logic [8:0]  cell_id;
  logic        busy;
  logic [30:0] c_init_o;
  logic        out_valid;
  logic        out_ready;
  logic        nrs_r;
  logic        nrs_i;
  logic [0:0]  pilot_idx;
  logic        done;

  logic        start_s;
  logic [4:0]  ns_s;
  logic [2:0]  l_s;
  logic [8:0]  cell_s;
  logic        busy_s;
  logic [30:0] c_init_s;
  logic        valid_s;
  logic        ready_s;
  logic        nrs_r_s;
  logic        nrs_i_s;
  logic [2:0]  idx_s;
  logic        done_s;

  int vectors = 0;
  int errors  = 0;
  bit ready_mode = 1'b0;

  always #5 clk = ~clk;

  nrs_gen #(.SKIP(SKIP), .NUM_PILOTS(NP), .IDX_W(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ns(ns), .l(l), .cell_id(cell_id),
    .busy(busy), .c_init_o(c_init_o), .out_valid(out_valid), .out_ready(out_ready),
    .nrs_r(nrs_r), .nrs_i(nrs_i), .pilot_idx(pilot_idx), .done(done)
  );

  nrs_gen #(.SKIP(0), .NUM_PILOTS(7), .IDX_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .ns(ns_s), .l(l_s), .cell_id(cell_s),
    .busy(busy_s), .c_init_o(c_init_s), .out_valid(valid_s), .out_ready(ready_s),
    .nrs_r(nrs_r_s), .nrs_i(nrs_i_s), .pilot_idx(idx_s), .done(done_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] ref_c_init(input int ns_v, input int l_v, input int cid);
    return 31'(1024 * (7 * (ns_v + 1) + l_v + 1) * (2 * cid + 1) + 2 * cid + 1);
  endfunction

  // c(n) from the m-sequence recurrences written directly on sample index
  function automatic bit gold_bit(input logic [30:0] ci, input int n);
    bit a [0:2100];
    bit b [0:2100];
    for (int i = 0; i < 31; i++) begin
      a[i] = (i == 0);
      b[i] = ci[i];
    end
    for (int i = 31; i <= n; i++) begin
      a[i] = a[i-31] ^ a[i-28];
      b[i] = b[i-31] ^ b[i-30] ^ b[i-29] ^ b[i-28];
    end
    return a[n] ^ b[n];
  endfunction

  bit          m_active = 1'b0;
  int          m_k, m_valid_k, m_end_k, m_got;
  logic [30:0] m_ci;
  bit          m_er [0:NP-1];
  bit          m_ei [0:NP-1];
  bit          e_busy, e_valid, e_done;

  always @(negedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_nrs", {nrs_r, nrs_i, pilot_idx}, 0);
      check("rst_c_init", c_init_o, 0);
    end else begin
      if (m_active) m_k++;
      e_done = m_active && (m_k == m_end_k);
      if (e_done) m_active = 1'b0;
      e_busy  = m_active;
      e_valid = m_active && (m_k >= m_valid_k);
      check("busy", busy, e_busy);
      check("out_valid", out_valid, e_valid);
      check("done", done, e_done);
      if (m_active && m_k >= 1) check("c_init_o", c_init_o, m_ci);
      if (e_valid && out_valid) begin
        check("nrs_r", nrs_r, m_er[m_got]);
        check("nrs_i", nrs_i, m_ei[m_got]);
        check("pilot_idx", pilot_idx, m_got);
      end
      if (e_valid && out_ready) begin
        m_got++;
        if (m_got == NP) begin
          m_end_k   = m_k + 1;
          m_valid_k = 1 << 30;
        end else begin
          m_valid_k = m_k + 3;
        end
      end
      if (!e_busy && start) begin
        m_active  = 1'b1;
        m_k       = -1;
        m_ci      = ref_c_init(int'(ns), int'(l), int'(cell_id));
        m_got     = 0;
        m_valid_k = SKIP + 3;
        m_end_k   = 1 << 30;
        for (int j = 0; j < NP; j++) begin
          m_er[j] = gold_bit(m_ci, SKIP + 2 * j);
          m_ei[j] = gold_bit(m_ci, SKIP + 2 * j + 1);
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic randomize_inputs();
    ns      = 5'($urandom_range(0, 19));
    l       = 3'($urandom_range(5, 6));
    cell_id = 9'($urandom_range(0, 503));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_req(input int ns_v, input int l_v, input int cid, input bit lit_en,
                         input logic [30:0] lit_ci);
    int cnt = 0;
    @(posedge clk);
    #1;
    ns = 5'(ns_v); l = 3'(l_v); cell_id = 9'(cid); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    randomize_inputs();
    while (!out_valid && cnt < 2000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 1 && lit_en) check("c_init_lit", c_init_o, lit_ci);
      if (cnt == 5) begin
        randomize_inputs();
        start = 1'b1;
      end
      if (cnt == 6) start = 1'b0;
    end
    check("first_valid_latency", cnt, 1821);
    wait_done(3000);
    @(negedge clk);
  endtask

  bit lit_c [0:13];
  int got_s, dn_s;

  initial begin
    rst = 1'b0; start = 1'b0; ns = '0; l = '0; cell_id = '0;
    start_s = 1'b0; ns_s = '0; l_s = 3'd5; cell_s = '0; ready_s = 1'b1;
    for (int i = 0; i < 14; i++) lit_c[i] = 1'b0;
    lit_c[10] = 1'b1; lit_c[12] = 1'b1; lit_c[13] = 1'b1;

    check("model_c_init_min", ref_c_init(0, 5, 0), 13313);
    check("model_c_init_max", ref_c_init(19, 6, 503), 151582703);
    for (int n = 0; n < 14; n++) check("model_gold", gold_bit(31'd13313, n), lit_c[n]);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_req(0, 5, 0, 1'b1, 31'd13313);
    run_req(19, 6, 503, 1'b1, 31'd151582703);
    for (int t = 0; t < 5; t++)
      run_req($urandom_range(0, 19), $urandom_range(5, 6), $urandom_range(0, 503), 1'b0, '0);

    ready_mode = 1'b1;
    run_req(0, 5, 0, 1'b1, 31'd13313);
    for (int t = 0; t < 5; t++)
      run_req($urandom_range(0, 19), $urandom_range(5, 6), $urandom_range(0, 503), 1'b0, '0);
    ready_mode = 1'b0;

    @(posedge clk);
    #1;
    randomize_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      randomize_inputs();
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_c_init", c_init_o, 0);
    check("abort_outs", {out_valid, done, nrs_r, nrs_i, pilot_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_req($urandom_range(0, 19), $urandom_range(5, 6), $urandom_range(0, 503), 1'b0, '0);

    got_s = 0;
    dn_s  = 0;
    @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (valid_s) begin
        if (got_s < 7) begin
          check("small_idx", idx_s, got_s);
          check("small_nrs_r", nrs_r_s, lit_c[2 * got_s]);
          check("small_nrs_i", nrs_i_s, lit_c[2 * got_s + 1]);
        end
        got_s++;
      end
      if (done_s) dn_s++;
    end
    check("small_pairs", got_s, 7);
    check("small_done_pulses", dn_s, 1);
    check("small_c_init", c_init_s, 13313);
    check("small_busy_end", busy_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
